// File: rtl/port_controller_if.sv
// Core-side request/response bundle for port_controller.
// master = the core issuing port I/O, slave = the controller.
interface port_controller_if #(
  parameter int WORD_SIZE = 8
);
  logic                 req_valid;
  logic                 req_write;
  logic [WORD_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_data;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [WORD_SIZE-1:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/port_controller.sv
// Port I/O sequencer: buffers writes in a FIFO and strobes them to the port block
// as setup/strobe pairs. Reads wait until the FIFO is empty. A write to port 0 halts.
//   state    | meaning
//   IDLE     | waiting; starts a drain or accepts a read
//   W_SETUP  | portaddr/portval driven from FIFO head, portset low
//   W_STROBE | portset high; head popped on exit, halt check on port 0
//   R_SETUP  | portaddr driven with read address, portget low
//   R_STROBE | portget high; portout captured into rsp_data on exit
module port_controller #(
  parameter int WORD_SIZE  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  port_controller_if.slave            bus,
  output logic                        halted,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [WORD_SIZE-1:0]        portaddr,
  output logic [WORD_SIZE-1:0]        portval,
  output logic                        portget,
  output logic                        portset,
  input  logic [WORD_SIZE-1:0]        portout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, W_SETUP, W_STROBE, R_SETUP, R_STROBE} state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] fifo_addr [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count_nxt;
  logic                 push, pop, rd_accept;

  logic [WORD_SIZE-1:0] portaddr_nxt, portval_nxt, rsp_data_nxt;
  logic                 portget_nxt, portset_nxt, rsp_valid_nxt, halted_nxt;

  assign bus.req_ready = bus.req_write
                       ? (!halted && (fifo_count < CNT_W'(FIFO_DEPTH)))
                       : (!halted && (state == IDLE) && (fifo_count == '0));

  assign push      = bus.req_valid && bus.req_ready &&  bus.req_write;
  assign rd_accept = bus.req_valid && bus.req_ready && !bus.req_write;

  always_comb begin
    count_nxt = fifo_count;
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + CNT_W'(1);
      2'b01:   count_nxt = fifo_count - CNT_W'(1);
      default: count_nxt = fifo_count;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    portaddr_nxt  = portaddr;
    portval_nxt   = portval;
    portget_nxt   = 1'b0;
    portset_nxt   = 1'b0;
    rsp_valid_nxt = 1'b0;
    rsp_data_nxt  = bus.rsp_data;
    halted_nxt    = halted;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0 && !halted) begin
          state_nxt    = W_SETUP;
          portaddr_nxt = fifo_addr[rd_ptr];
          portval_nxt  = fifo_data[rd_ptr];
        end else if (rd_accept) begin
          state_nxt    = R_SETUP;
          portaddr_nxt = bus.req_addr;
        end
      end
      W_SETUP: begin
        state_nxt   = W_STROBE;
        portset_nxt = 1'b1;
      end
      W_STROBE: begin
        pop = 1'b1;
        // Chaining only from entries already in memory; a same-edge push drains via IDLE.
        if (portaddr == '0) begin
          halted_nxt = 1'b1;
          state_nxt  = IDLE;
        end else if (fifo_count > CNT_W'(1)) begin
          state_nxt    = W_SETUP;
          portaddr_nxt = fifo_addr[rd_ptr + PTR_W'(1)];
          portval_nxt  = fifo_data[rd_ptr + PTR_W'(1)];
        end else begin
          state_nxt = IDLE;
        end
      end
      R_SETUP: begin
        state_nxt   = R_STROBE;
        portget_nxt = 1'b1;
      end
      R_STROBE: begin
        state_nxt     = IDLE;
        rsp_valid_nxt = 1'b1;
        rsp_data_nxt  = portout;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      portaddr     <= '0;
      portval      <= '0;
      portget      <= 1'b0;
      portset      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      halted       <= 1'b0;
    end else begin
      state        <= state_nxt;
      fifo_count   <= count_nxt;
      portaddr     <= portaddr_nxt;
      portval      <= portval_nxt;
      portget      <= portget_nxt;
      portset      <= portset_nxt;
      bus.rsp_valid <= rsp_valid_nxt;
      bus.rsp_data  <= rsp_data_nxt;
      halted       <= halted_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.req_addr;
      fifo_data[wr_ptr] <= bus.req_data;
    end
  end

endmodule
